// File: rtl/ack_bus_pkg.sv
// Shared definitions for the acknowledge-bus arbiter: FSM state encoding and
// arbitration mode constants.
package ack_bus_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    typedef enum logic [1:0] {
        IDLE    = ST_IDLE,
        GRANT   = ST_GRANT,
        RELEASE = ST_RELEASE
    } state_e;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

endpackage

// File: rtl/ack_bus_rr_pick.sv
// Combinational rotating-priority encoder: returns the first requesting index
// at or above the pointer (wrapping), or the lowest index when rotation is off.
module ack_bus_rr_pick
    import ack_bus_pkg::*;
#(
    parameter int N_SRC = 4,
    parameter int ID_W  = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] req_i,
    input  logic [ID_W-1:0]  ptr_i,
    input  logic             rr_i,
    output logic             valid_o,
    output logic [ID_W-1:0]  index_o
);

    // Scan from the farthest offset down so the nearest requester wins last.
    always_comb begin
        int base;
        int pos;
        base    = rr_i ? int'(ptr_i) : 0;
        pos     = 0;
        valid_o = 1'b0;
        index_o = '0;
        for (int off = N_SRC - 1; off >= 0; off--) begin
            pos = (base + off) % N_SRC;
            if (req_i[pos]) begin
                valid_o = 1'b1;
                index_o = ID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/ack_bus_rr_arbiter.sv
// Registered N-source acknowledge-bus arbiter with fixed or round-robin
// priority, grant holding, a turnaround cycle and a hold-limit timeout.
module ack_bus_rr_arbiter
    import ack_bus_pkg::*;
#(
    parameter int N_SRC    = 4,
    parameter int ID_W     = $clog2(N_SRC),
    parameter int ARB_MODE = 0,
    parameter int HOLD_MAX = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_SRC-1:0] req,
    input  logic [N_SRC-1:0] done,
    output logic [N_SRC-1:0] grant,
    output logic [ID_W-1:0]  winner_id,
    output logic             ack_event,
    output logic             busy,
    output logic             timeout_event
);

    localparam int   CNT_W   = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);
    localparam logic RR_MODE = (ARB_MODE != ARB_FIXED);

    state_e             state_q;
    logic [N_SRC-1:0]   grant_q;
    logic [N_SRC-1:0]   grant_d;
    logic [ID_W-1:0]    winner_q;
    logic [ID_W-1:0]    ptr_q;
    logic [ID_W-1:0]    ptr_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               ack_q;
    logic               tout_q;
    logic               busy_q;

    logic               pickValid;
    logic [ID_W-1:0]    pickIdx;
    logic               winDone;
    logic               winReq;
    logic               limitHit;
    logic               releaseNow;
    logic               timeoutOnly;

    ack_bus_rr_pick #(
        .N_SRC (N_SRC),
        .ID_W  (ID_W)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (ptr_q),
        .rr_i    (RR_MODE),
        .valid_o (pickValid),
        .index_o (pickIdx)
    );

    // A timeout only counts as the cause when the winner is neither done nor gone.
    always_comb begin
        grant_d     = N_SRC'(1) << pickIdx;
        ptr_d       = (int'(pickIdx) == N_SRC - 1) ? '0 : pickIdx + ID_W'(1);
        winDone     = done[winner_q];
        winReq      = req[winner_q];
        limitHit    = (HOLD_MAX != 0) && (cnt_q == CNT_W'(HOLD_MAX));
        releaseNow  = winDone || !winReq || limitHit;
        timeoutOnly = limitHit && winReq && !winDone;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            winner_q <= '0;
            ptr_q    <= '0;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            tout_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            ack_q  <= 1'b0;
            tout_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (pickValid) begin
                        state_q  <= GRANT;
                        grant_q  <= grant_d;
                        winner_q <= pickIdx;
                        ptr_q    <= ptr_d;
                        cnt_q    <= CNT_W'(1);
                        ack_q    <= 1'b1;
                        busy_q   <= 1'b1;
                    end
                end
                GRANT: begin
                    if (releaseNow) begin
                        state_q <= RELEASE;
                        grant_q <= '0;
                        tout_q  <= timeoutOnly;
                    end else if (cnt_q != '1) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                RELEASE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign grant         = grant_q;
    assign winner_id     = winner_q;
    assign ack_event     = ack_q;
    assign busy          = busy_q;
    assign timeout_event = tout_q;

endmodule

// File: tb/tb_ack_bus_rr_arbiter.sv
// Self-checking bench: a fixed-priority and a round-robin arbiter share inputs
// and are compared every cycle against a queue-based arbitration model.
module tb_ack_bus_rr_arbiter;

    localparam int N_SRC    = 4;
    localparam int ID_W     = 2;
    localparam int HOLD_MAX = 4;

    logic             clk;
    logic             rst;
    logic [N_SRC-1:0] req;
    logic [N_SRC-1:0] done;

    logic [N_SRC-1:0] grantF, grantR;
    logic [ID_W-1:0]  winnerF, winnerR;
    logic             ackF, ackR, busyF, busyR, toutF, toutR;

    int passCount = 0;
    int checkCount = 0;
    int failCount = 0;

    // Model state per DUT: index 0 = fixed priority, 1 = round robin.
    int mPhase [2];
    int mWin   [2];
    int mPtr   [2];
    int mHeld  [2];
    int mGrant [2];
    int mAck   [2];
    int mTout  [2];
    int mBusy  [2];

    ack_bus_rr_arbiter #(
        .N_SRC (N_SRC), .ID_W (ID_W), .ARB_MODE (0), .HOLD_MAX (HOLD_MAX)
    ) dutFixed (
        .clk (clk), .rst (rst), .req (req), .done (done),
        .grant (grantF), .winner_id (winnerF), .ack_event (ackF),
        .busy (busyF), .timeout_event (toutF)
    );

    ack_bus_rr_arbiter #(
        .N_SRC (N_SRC), .ID_W (ID_W), .ARB_MODE (1), .HOLD_MAX (HOLD_MAX)
    ) dutRr (
        .clk (clk), .rst (rst), .req (req), .done (done),
        .grant (grantR), .winner_id (winnerR), .ack_event (ackR),
        .busy (busyR), .timeout_event (toutR)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance the model one clock edge from the arbitration rules.
    task automatic modelStep(input int m);
        int order[$];
        int base;
        int w;
        if (rst) begin
            mPhase[m] = 0; mWin[m] = 0; mPtr[m] = 0; mHeld[m] = 0;
            mGrant[m] = 0; mAck[m] = 0; mTout[m] = 0; mBusy[m] = 0;
            return;
        end
        mAck[m]  = 0;
        mTout[m] = 0;
        if (mPhase[m] == 0) begin
            base = (m == 1) ? mPtr[m] : 0;
            for (int k = 0; k < N_SRC; k++)
                if (req[(base + k) % N_SRC]) order.push_back((base + k) % N_SRC);
            if (order.size() > 0) begin
                w = order[0];
                mPhase[m] = 1; mWin[m] = w; mHeld[m] = 1;
                mPtr[m] = (w + 1) % N_SRC;
                mGrant[m] = 1 << w; mAck[m] = 1; mBusy[m] = 1;
            end
        end else if (mPhase[m] == 1) begin
            if (done[mWin[m]] || !req[mWin[m]] || mHeld[m] == HOLD_MAX) begin
                mTout[m]  = (mHeld[m] == HOLD_MAX && req[mWin[m]] && !done[mWin[m]]) ? 1 : 0;
                mPhase[m] = 2;
                mGrant[m] = 0;
            end else begin
                mHeld[m]++;
            end
        end else begin
            mPhase[m] = 0;
            mBusy[m]  = 0;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic [3:0] d, input logic rs);
        @(negedge clk);
        req  = r;
        done = d;
        rst  = rs;
        @(posedge clk);
        modelStep(0);
        modelStep(1);
        #1;
        checkOutput("fix.grant",   32'(grantF),  32'(mGrant[0]));
        checkOutput("fix.winner",  32'(winnerF), 32'(mWin[0]));
        checkOutput("fix.ack",     32'(ackF),    32'(mAck[0]));
        checkOutput("fix.busy",    32'(busyF),   32'(mBusy[0]));
        checkOutput("fix.timeout", 32'(toutF),   32'(mTout[0]));
        checkOutput("rr.grant",    32'(grantR),  32'(mGrant[1]));
        checkOutput("rr.winner",   32'(winnerR), 32'(mWin[1]));
        checkOutput("rr.ack",      32'(ackR),    32'(mAck[1]));
        checkOutput("rr.busy",     32'(busyR),   32'(mBusy[1]));
        checkOutput("rr.timeout",  32'(toutR),   32'(mTout[1]));
        checkOutput("fix.onehot",  32'($countones(grantF) <= 1), 32'(1));
        checkOutput("rr.onehot",   32'($countones(grantR) <= 1), 32'(1));
    endtask

    initial begin
        int found;
        rst  = 1'b1;
        req  = '0;
        done = '0;

        $display("[TB] reset");
        repeat (3) applyStimulus(4'b0000, 4'b0000, 1'b1);
        checkOutput("reset.grant", 32'(grantF), 32'(0));

        $display("[TB] fixed priority vs rotation, req=1110");
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        repeat (12) applyStimulus(4'b1110, 4'b1110, 1'b0);

        $display("[TB] full saturation, req=1111");
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        repeat (15) applyStimulus(4'b1111, 4'b1111, 1'b0);

        $display("[TB] timeout on source 3");
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        repeat (14) applyStimulus(4'b1000, 4'b0000, 1'b0);

        $display("[TB] done coincident with hold limit");
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        found = 0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(4'b1000, 4'b0000, 1'b0);
            if (mPhase[0] == 1 && mHeld[0] == HOLD_MAX) begin
                found = 1;
                break;
            end
        end
        checkOutput("limit.sync", 32'(found), 32'(1));
        applyStimulus(4'b1000, 4'b1000, 1'b0);
        checkOutput("limit.timeout", 32'(toutF), 32'(0));
        checkOutput("limit.grant",   32'(grantF), 32'(0));

        $display("[TB] done on non-winners ignored");
        repeat (3) applyStimulus(4'b1000, 4'b0000, 1'b0);
        repeat (2) applyStimulus(4'b1000, 4'b0111, 1'b0);
        checkOutput("nonwin.grant", 32'(grantF), 32'(4'b1000));

        $display("[TB] requester drops req");
        applyStimulus(4'b0000, 4'b0000, 1'b1);
        repeat (2) applyStimulus(4'b0100, 4'b0000, 1'b0);
        repeat (5) applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("drop.winner", 32'(winnerF), 32'(2));

        $display("[TB] reset mid-grant");
        repeat (2) applyStimulus(4'b0100, 4'b0000, 1'b0);
        applyStimulus(4'b0100, 4'b0000, 1'b1);
        checkOutput("rstmid.winner", 32'(winnerR), 32'(0));
        repeat (4) applyStimulus(4'b0000, 4'b0000, 1'b0);
        checkOutput("rstmid.busy", 32'(busyR), 32'(0));

        $display("[TB] randomized traffic");
        for (int k = 0; k < 300; k++) begin
            applyStimulus(4'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000,
                          ($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
